// File: rtl/axi_lite_timeout_guard_if.sv
// AXI-Lite bundle used on both sides of the timeout guard.
// "master" drives requests and response-ready; "slave" drives request-ready and responses.
interface axi_lite_timeout_guard_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_timeout_guard.sv
// AXI-Lite guard: one outstanding write and one outstanding read, DECERR for out-of-window
// addresses and SLVERR when a forwarded access gets no response within TIMEOUT_CYCLES.
module axi_lite_timeout_guard #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LO        = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HI        = 'h00FF_FFFF,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = 'hDEAD_BEEF
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  axi_lite_timeout_guard_if.slave   s,
  axi_lite_timeout_guard_if.master  m,
  output logic                      err_timeout,
  output logic                      err_decode,
  output logic [15:0]               timeout_cnt
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [1:0]       RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP, W_DONE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP, R_DONE} r_state_e;

  // Unsigned wrap-around keeps this a single compare even when ADDR_LO is zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - ADDR_LO) <= (ADDR_HI - ADDR_LO);
  endfunction

  w_state_e                w_state, w_next;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    aw_sent, w_sent;
  logic [CNT_W-1:0]        w_cnt;
  logic [1:0]              bresp_q;
  logic                    w_accept, w_decerr, w_timeout, w_resp_hit;

  r_state_e                r_state, r_next;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic                    ar_sent;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic                    r_accept, r_decerr, r_timeout, r_resp_hit;

  logic [16:0]             timeout_sum;

  // Responses are always sunk so a stray or late reply can never stall the interconnect.
  assign m.bready = 1'b1;
  assign m.rready = 1'b1;

  assign m.awaddr  = aw_addr_q;
  assign m.wdata   = w_data_q;
  assign m.wstrb   = w_strb_q;
  assign m.araddr  = ar_addr_q;
  assign s.bresp   = bresp_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = w_state;
    s.awready  = 1'b0;
    s.wready   = 1'b0;
    s.bvalid   = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    w_accept   = 1'b0;
    w_decerr   = 1'b0;
    w_timeout  = 1'b0;
    w_resp_hit = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s.awready = s.awvalid && s.wvalid;
        s.wready  = s.awvalid && s.wvalid;
        if (s.awvalid && s.wvalid) begin
          w_accept = 1'b1;
          if (in_range(s.awaddr)) begin
            w_next = W_ISSUE;
          end else begin
            w_decerr = 1'b1;
            w_next   = W_DONE;
          end
        end
      end
      W_ISSUE: begin
        m.awvalid = !aw_sent;
        m.wvalid  = !w_sent;
        // Dropping valid before ready on timeout is deliberate: it frees a dead slave.
        if (w_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = W_DONE;
        end else if ((aw_sent || m.awready) && (w_sent || m.wready)) begin
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (m.bvalid) begin
          w_resp_hit = 1'b1;
          w_next     = W_DONE;
        end else if (w_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = W_DONE;
        end
      end
      W_DONE: begin
        s.bvalid = 1'b1;
        if (s.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_sent   <= 1'b0;
      w_sent    <= 1'b0;
      w_cnt     <= '0;
      bresp_q   <= 2'b00;
    end else begin
      if (w_accept) begin
        aw_addr_q <= s.awaddr;
        w_data_q  <= s.wdata;
        w_strb_q  <= s.wstrb;
        aw_sent   <= 1'b0;
        w_sent    <= 1'b0;
        w_cnt     <= '0;
      end
      if (w_state == W_ISSUE || w_state == W_RESP) w_cnt <= w_cnt + CNT_W'(1);
      if (m.awvalid && m.awready) aw_sent <= 1'b1;
      if (m.wvalid && m.wready)   w_sent  <= 1'b1;
      if (w_decerr)   bresp_q <= RESP_DECERR;
      if (w_timeout)  bresp_q <= RESP_SLVERR;
      if (w_resp_hit) bresp_q <= m.bresp;
    end
  end

  always_comb begin
    r_next     = r_state;
    s.arready  = 1'b0;
    s.rvalid   = 1'b0;
    m.arvalid  = 1'b0;
    r_accept   = 1'b0;
    r_decerr   = 1'b0;
    r_timeout  = 1'b0;
    r_resp_hit = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s.arready = s.arvalid;
        if (s.arvalid) begin
          r_accept = 1'b1;
          if (in_range(s.araddr)) begin
            r_next = R_ISSUE;
          end else begin
            r_decerr = 1'b1;
            r_next   = R_DONE;
          end
        end
      end
      R_ISSUE: begin
        m.arvalid = !ar_sent;
        if (r_cnt == CNT_LAST) begin
          r_timeout = 1'b1;
          r_next    = R_DONE;
        end else if (ar_sent || m.arready) begin
          r_next = R_RESP;
        end
      end
      R_RESP: begin
        if (m.rvalid) begin
          r_resp_hit = 1'b1;
          r_next     = R_DONE;
        end else if (r_cnt == CNT_LAST) begin
          r_timeout = 1'b1;
          r_next    = R_DONE;
        end
      end
      R_DONE: begin
        s.rvalid = 1'b1;
        if (s.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ar_addr_q <= '0;
      ar_sent   <= 1'b0;
      r_cnt     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      if (r_accept) begin
        ar_addr_q <= s.araddr;
        ar_sent   <= 1'b0;
        r_cnt     <= '0;
      end
      if (r_state == R_ISSUE || r_state == R_RESP) r_cnt <= r_cnt + CNT_W'(1);
      if (m.arvalid && m.arready) ar_sent <= 1'b1;
      if (r_decerr) begin
        rdata_q <= ERR_RDATA;
        rresp_q <= RESP_DECERR;
      end
      if (r_timeout) begin
        rdata_q <= ERR_RDATA;
        rresp_q <= RESP_SLVERR;
      end
      if (r_resp_hit) begin
        rdata_q <= m.rdata;
        rresp_q <= m.rresp;
      end
    end
  end

  // Both paths can time out on the same edge, so the counter may step by two.
  always_comb begin
    timeout_sum = {1'b0, timeout_cnt} + 17'(w_timeout) + 17'(r_timeout);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      err_timeout <= 1'b0;
      err_decode  <= 1'b0;
      timeout_cnt <= 16'h0000;
    end else begin
      err_timeout <= w_timeout || r_timeout;
      err_decode  <= w_decerr || r_decerr;
      timeout_cnt <= timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_lite_timeout_guard.sv
// Randomized bench for axi_lite_timeout_guard: a cycle-scheduled slave plus an arithmetic
// model of when and with what each upstream response must appear.
module tb_axi_lite_timeout_guard;

  localparam int          T     = 16;
  localparam logic [31:0] HI    = 32'h00FF_FFFF;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
  localparam int          BOUND = 150;

  typedef struct {
    bit          en;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or the slave's read data
    logic [3:0]  strb;
    int          a_lat;  // cycles after first possible issue cycle that address ready arrives
    int          w_lat;
    int          r_lat;  // cycles after issue completes that the response arrives; <0 = never
    logic [1:0]  resp;
  } txn_t;

  typedef struct {
    bit          fwd;
    bit          to;
    int          a_hs;
    int          w_hs;
    int          rsp_cyc;
    int          a_cnt;
    int          w_cnt;
    int          v_cyc;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_timeout, err_decode;
  logic [15:0] timeout_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          tc_model = 0;

  always #5 CLK = ~CLK;

  axi_lite_timeout_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axi_lite_timeout_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axi_lite_timeout_guard #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_LO(32'h0), .ADDR_HI(HI),
    .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .s(s_if), .m(m_if),
    .err_timeout(err_timeout), .err_decode(err_decode), .timeout_cnt(timeout_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(bit en, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                              int a_lat, int w_lat, int r_lat, logic [1:0] resp);
    txn_t t;
    t.en = en; t.addr = addr; t.data = data; t.strb = strb;
    t.a_lat = a_lat; t.w_lat = w_lat; t.r_lat = r_lat; t.resp = resp;
    return t;
  endfunction

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  // Accept is cycle 0, downstream valid from cycle 1; the response may arrive up to cycle T.
  function automatic exp_t predict(txn_t t, bit is_read);
    exp_t e;
    int   hs;
    e.fwd     = (t.addr <= HI);  // window starts at address 0
    e.a_hs    = 1 + t.a_lat;
    e.w_hs    = is_read ? 1 : 1 + t.w_lat;
    hs        = imax(e.a_hs, e.w_hs);
    e.rsp_cyc = (t.r_lat < 0) ? -1 : hs + 1 + t.r_lat;
    e.a_cnt   = e.fwd ? imin(e.a_hs, T) : 0;
    e.w_cnt   = (e.fwd && !is_read) ? imin(e.w_hs, T) : 0;
    if (!e.fwd) begin
      e.to = 1'b0; e.v_cyc = 1; e.resp = 2'b11; e.rdata = ERR;
    end else if (e.rsp_cyc >= 0 && e.rsp_cyc <= T) begin
      e.to = 1'b0; e.v_cyc = e.rsp_cyc + 1; e.resp = t.resp; e.rdata = t.data;
    end else begin
      e.to = 1'b1; e.v_cyc = T + 1; e.resp = 2'b10; e.rdata = ERR;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    s_if.bready  = 1'b0; s_if.rready = 1'b0;
    s_if.awaddr  = '0;   s_if.wdata  = '0;   s_if.wstrb   = '0; s_if.araddr = '0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid  = 1'b0; m_if.bresp  = 2'b00;
    m_if.rvalid  = 1'b0; m_if.rresp  = 2'b00; m_if.rdata  = '0;
  endtask

  // Both enabled paths are accepted in cycle 0; abort_at >= 0 pulses reset in that cycle.
  task automatic run_pair(input txn_t wr, input txn_t rd, input int abort_at);
    exp_t        we, re;
    int          c, last_ev, exp_dec, exp_to, dec_n, to_n;
    int          wa_first, ww_first, ra_first, bv_first, rv_first, wa_cnt, ww_cnt, ra_cnt;
    bit          w_done, r_done, w_dec, r_dec, w_to, r_to;
    logic [1:0]  b_obs, r_obs;
    logic [31:0] rd_obs;

    we = predict(wr, 1'b0);
    re = predict(rd, 1'b1);
    w_dec = wr.en && !we.fwd;  r_dec = rd.en && !re.fwd;
    w_to  = wr.en && we.to;    r_to  = rd.en && re.to;
    exp_dec = (w_dec && r_dec) ? 1 : int'(w_dec) + int'(r_dec);
    exp_to  = (w_to && r_to)   ? 1 : int'(w_to) + int'(r_to);
    last_ev = 0;
    if (wr.en) last_ev = imax(last_ev, imax(imax(we.a_hs, we.w_hs), we.rsp_cyc));
    if (rd.en) last_ev = imax(last_ev, imax(re.a_hs, re.rsp_cyc));
    wa_first = -1; ww_first = -1; ra_first = -1; bv_first = -1; rv_first = -1;
    wa_cnt = 0; ww_cnt = 0; ra_cnt = 0; dec_n = 0; to_n = 0;
    w_done = 1'b0; r_done = 1'b0;
    b_obs = 2'b00; r_obs = 2'b00; rd_obs = '0;

    for (c = 0; c < BOUND; c++) begin
      s_if.awvalid = wr.en && (c == 0);
      s_if.wvalid  = wr.en && (c == 0);
      s_if.awaddr  = wr.addr; s_if.wdata = wr.data; s_if.wstrb = wr.strb;
      s_if.arvalid = rd.en && (c == 0);
      s_if.araddr  = rd.addr;
      s_if.bready  = w_done ? 1'b0 : 1'($urandom_range(0, 1));
      s_if.rready  = r_done ? 1'b0 : 1'($urandom_range(0, 1));
      m_if.awready = wr.en && (c == we.a_hs);
      m_if.wready  = wr.en && (c == we.w_hs);
      m_if.bvalid  = wr.en && (c == we.rsp_cyc);
      m_if.bresp   = wr.resp;
      m_if.arready = rd.en && (c == re.a_hs);
      m_if.rvalid  = rd.en && (c == re.rsp_cyc);
      m_if.rdata   = rd.data;
      m_if.rresp   = rd.resp;
      @(negedge CLK);
      if (c == 0 && wr.en) check("w_accept", 64'(s_if.awready && s_if.wready), 64'(1));
      if (c == 0 && rd.en) check("r_accept", 64'(s_if.arready), 64'(1));
      if (m_if.awvalid) begin
        wa_cnt++;
        if (wa_first < 0) begin wa_first = c; check("m_awaddr", 64'(m_if.awaddr), 64'(wr.addr)); end
      end
      if (m_if.wvalid) begin
        ww_cnt++;
        if (ww_first < 0) begin
          ww_first = c;
          check("m_wdata", 64'(m_if.wdata), 64'(wr.data));
          check("m_wstrb", 64'(m_if.wstrb), 64'(wr.strb));
        end
      end
      if (m_if.arvalid) begin
        ra_cnt++;
        if (ra_first < 0) begin ra_first = c; check("m_araddr", 64'(m_if.araddr), 64'(rd.addr)); end
      end
      if (s_if.bvalid && bv_first < 0) begin bv_first = c; b_obs = s_if.bresp; end
      if (s_if.rvalid && rv_first < 0) begin rv_first = c; r_obs = s_if.rresp; rd_obs = s_if.rdata; end
      if (s_if.bvalid && s_if.bready) w_done = 1'b1;
      if (s_if.rvalid && s_if.rready) r_done = 1'b1;
      dec_n += int'(err_decode);
      to_n  += int'(err_timeout);
      if (c == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        check("abort_s_bvalid", 64'(s_if.bvalid), 64'(0));
        check("abort_m_awvalid", 64'(m_if.awvalid || m_if.wvalid), 64'(0));
        check("abort_m_bready", 64'(m_if.bready), 64'(1));
        check("abort_timeout_cnt", 64'(timeout_cnt), 64'(0));
        tc_model = 0;
        idle_inputs();
        @(posedge CLK);
        #1 reset_n = 1'b1;
        @(posedge CLK);
        #1;
        return;
      end
      @(posedge CLK);
      #1;
      if ((!wr.en || w_done) && (!rd.en || r_done) && c >= last_ev) break;
    end
    idle_inputs();
    if (c >= BOUND) check("cycle_bound", 64'(c), 64'(0));

    tc_model += int'(w_to) + int'(r_to);
    if (wr.en) begin
      check("w_awvalid_rise", 64'(wa_first), we.fwd ? 64'(1) : 64'(-1));
      check("w_awvalid_cycles", 64'(wa_cnt), 64'(we.a_cnt));
      check("w_wvalid_cycles", 64'(ww_cnt), 64'(we.w_cnt));
      check("s_bvalid_cycle", 64'(bv_first), 64'(we.v_cyc));
      check("s_bresp", 64'(b_obs), 64'(we.resp));
    end
    if (rd.en) begin
      check("r_arvalid_rise", 64'(ra_first), re.fwd ? 64'(1) : 64'(-1));
      check("r_arvalid_cycles", 64'(ra_cnt), 64'(re.a_cnt));
      check("s_rvalid_cycle", 64'(rv_first), 64'(re.v_cyc));
      check("s_rresp", 64'(r_obs), 64'(re.resp));
      check("s_rdata", 64'(rd_obs), 64'(re.rdata));
    end
    check("err_decode_pulses", 64'(dec_n), 64'(exp_dec));
    check("err_timeout_pulses", 64'(to_n), 64'(exp_to));
    check("timeout_cnt", 64'(timeout_cnt), 64'(tc_model));
  endtask

  initial begin
    txn_t none, wr, rd;
    none = mk(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00);
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valids", 64'({s_if.bvalid, s_if.rvalid, m_if.awvalid, m_if.wvalid, m_if.arvalid}), 64'(0));
    check("rst_resp_data", 64'({s_if.bresp, s_if.rresp, s_if.rdata}), 64'(0));
    check("rst_err", 64'({err_timeout, err_decode}), 64'(0));
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("rst_m_ready", 64'({m_if.bready, m_if.rready}), 64'(2'b11));
    reset_n = 1'b1;
    @(posedge CLK);
    #1;

    // Plain forwarded write, then an out-of-window read.
    run_pair(mk(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 2, 2, 1, 2'b00), none, -1);
    run_pair(none, mk(1'b1, 32'h0100_0000, 32'h0, 4'h0, 0, 0, 0, 2'b00), -1);
    // Dead read target, then replies exactly on and one past the terminal cycle.
    run_pair(none, mk(1'b1, 32'h4, 32'h0, 4'h0, 0, 0, -1, 2'b00), -1);
    run_pair(none, mk(1'b1, 32'h4, 32'h1234, 4'h0, 0, 0, 14, 2'b00), -1);
    run_pair(none, mk(1'b1, 32'h4, 32'h5678, 4'h0, 0, 0, 15, 2'b00), -1);
    // Write times out, its late reply arrives as a stray, then a normal write.
    run_pair(mk(1'b1, 32'h8, 32'h1111_2222, 4'h3, 0, 0, 20, 2'b00), none, -1);
    run_pair(mk(1'b1, 32'h20, 32'h3333_4444, 4'hC, 0, 1, 3, 2'b00), none, -1);
    // Reset while waiting for the write response, then a normal write.
    run_pair(mk(1'b1, 32'h30, 32'h5555_6666, 4'hF, 0, 0, -1, 2'b00), none, 5);
    run_pair(mk(1'b1, 32'h34, 32'h7777_8888, 4'hF, 1, 0, 0, 2'b01), none, -1);
    // Both paths time out together, both decode-error together.
    run_pair(mk(1'b1, 32'h40, 32'h0, 4'hF, 0, 0, -1, 2'b00), mk(1'b1, 32'h44, 32'h0, 4'h0, 0, 0, -1, 2'b00), -1);
    run_pair(mk(1'b1, 32'hFFFF_0000, 32'h0, 4'hF, 0, 0, 0, 2'b00), mk(1'b1, 32'h0200_0000, 32'h0, 4'h0, 0, 0, 0, 2'b00), -1);
    // Timeout while the address handshake is still pending; window edges.
    run_pair(mk(1'b1, 32'h50, 32'h9999_AAAA, 4'h1, 20, 0, 0, 2'b00), none, -1);
    run_pair(mk(1'b1, HI, 32'hBBBB_CCCC, 4'hF, 0, 0, 0, 2'b10), mk(1'b1, HI, 32'hCAFE_F00D, 4'h0, 3, 0, 2, 2'b00), -1);
    run_pair(mk(1'b1, HI + 32'h1, 32'h0, 4'hF, 0, 0, 0, 2'b00), mk(1'b1, HI + 32'h1, 32'h0, 4'h0, 0, 0, 0, 2'b00), -1);

    for (int i = 0; i < 40; i++) begin
      wr = mk(1'b1, ($urandom_range(0, 3) == 0) ? ($urandom | 32'h0100_0000) : ($urandom & 32'h00FF_FFFC),
              $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 12), $urandom_range(0, 12),
              int'($urandom_range(0, 16)) - 1, 2'($urandom_range(0, 2)));
      rd = mk(1'b1, ($urandom_range(0, 3) == 0) ? ($urandom | 32'h0100_0000) : ($urandom & 32'h00FF_FFFC),
              $urandom, 4'h0, $urandom_range(0, 12), 0,
              int'($urandom_range(0, 16)) - 1, 2'($urandom_range(0, 2)));
      wr.en = ($urandom_range(0, 3) != 0);
      rd.en = ($urandom_range(0, 3) != 0);
      run_pair(wr, rd, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
